// File: rtl/ife_pkg.sv
// Shared IFE types: block record, serializer states and slot-width helper.
package ife_pkg;

  localparam int IFE_BLOCK_ID_WIDTH = 8;
  localparam int IFE_INSTR_WIDTH    = 32;
  localparam int IFE_BLOCK_SIZE     = 4;

  // Slot index width; a single-slot block still needs one bit.
  function automatic int IFE_SLOT_W(input int block_size);
    return (block_size > 1) ? $clog2(block_size) : 1;
  endfunction

  typedef struct packed {
    logic [IFE_BLOCK_ID_WIDTH-1:0]                id;
    logic [IFE_BLOCK_SIZE*IFE_INSTR_WIDTH-1:0]    instrs;
    logic                                         is_fallback;
  } ife_block_t;

  typedef enum logic {
    IFE_SER_IDLE = 1'b0,
    IFE_SER_EMIT = 1'b1
  } ife_ser_state_e;

endpackage

// File: rtl/ife_sat_counter.sv
// Generic saturating up-counter; holds at all-ones until reset.
module ife_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ife_block_serializer.sv
// Accepts a whole instruction block and emits it one slot per cycle with
// valid/ready on both sides; counts accepted fallback blocks.
module ife_block_serializer
  import ife_pkg::*;
#(
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int INSTR_WIDTH    = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int CNT_WIDTH      = 16,
  localparam int SLOT_W        = IFE_SLOT_W(BLOCK_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BLOCK_ID_WIDTH-1:0]         block_id_in,
  input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_in,
  input  logic                              is_fallback_in,
  input  logic                              valid_in,
  output logic                              ready_in,
  input  logic                              flush,
  output logic [INSTR_WIDTH-1:0]            instr_out,
  output logic [SLOT_W-1:0]                 slot_out,
  output logic [BLOCK_ID_WIDTH-1:0]         block_id_out,
  output logic                              is_fallback_out,
  output logic                              first_out,
  output logic                              last_out,
  output logic                              valid_out,
  input  logic                              ready_out,
  output logic                              busy,
  output logic [CNT_WIDTH-1:0]              fallback_cnt
);

  // Buffer is padded to a power of two so any slot code indexes in range.
  localparam int                DEPTH     = 1 << SLOT_W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BLOCK_SIZE - 1);

  ife_ser_state_e                state_q, state_d;
  logic [SLOT_W-1:0]             slot_q, slot_d;
  logic [BLOCK_ID_WIDTH-1:0]     id_q, id_d;
  logic                          fb_q, fb_d;
  logic [INSTR_WIDTH-1:0]        buf_q [DEPTH];
  logic [INSTR_WIDTH-1:0]        blk_words [BLOCK_SIZE];

  logic emit;
  logic at_last;
  logic accept;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_unpack
      assign blk_words[gi] = block_in[gi*INSTR_WIDTH +: INSTR_WIDTH];
    end
  endgenerate

  assign emit    = (state_q == IFE_SER_EMIT);
  assign at_last = emit && (slot_q == LAST_SLOT);
  // Reload on the last beat keeps back-to-back blocks bubble-free.
  assign ready_in = !flush && (!emit || (at_last && ready_out));
  assign accept   = valid_in && ready_in;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    id_d    = id_q;
    fb_d    = fb_q;
    if (flush) begin
      state_d = IFE_SER_IDLE;
      slot_d  = '0;
    end else if (accept) begin
      state_d = IFE_SER_EMIT;
      slot_d  = '0;
      id_d    = block_id_in;
      fb_d    = is_fallback_in;
    end else if (emit && ready_out) begin
      if (at_last) begin
        state_d = IFE_SER_IDLE;
        slot_d  = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFE_SER_IDLE;
      slot_q  <= '0;
      id_q    <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      id_q    <= id_d;
      fb_q    <= fb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        buf_q[i] <= blk_words[i];
      end
    end
  end

  assign instr_out       = buf_q[slot_q];
  assign slot_out        = slot_q;
  assign block_id_out    = id_q;
  assign is_fallback_out = fb_q;
  assign valid_out       = emit;
  assign busy            = emit;
  assign first_out       = emit && (slot_q == '0);
  assign last_out        = at_last;

  ife_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_fb_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (accept && is_fallback_in),
    .count_o (fallback_cnt)
  );

endmodule

// File: tb/tb_ife_block_serializer.sv
// Directed bench for ife_block_serializer: cycle table plus corner sequences.
module tb_ife_block_serializer;

  localparam logic [31:0] KA = 32'hA000_0000;
  localparam logic [31:0] KB = 32'hB000_0000;
  localparam logic [31:0] KC = 32'hC000_0000;
  localparam logic [31:0] KD = 32'hD000_0000;
  localparam logic [31:0] KE = 32'hE000_0000;
  localparam logic [31:0] KF = 32'hF000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Main instance: BLOCK_SIZE 4, CNT_WIDTH 16
  logic [7:0]   m_id, m_id_o;
  logic [127:0] m_blk;
  logic         m_fb, m_valid, m_ready_in, m_flush, m_fb_o, m_first, m_last;
  logic         m_valid_o, m_ready_out, m_busy;
  logic [31:0]  m_instr;
  logic [1:0]   m_slot;
  logic [15:0]  m_cnt;

  // Saturation instance: CNT_WIDTH 2
  logic [7:0]   s_id, s_id_o;
  logic [127:0] s_blk;
  logic         s_fb, s_valid, s_ready_in, s_flush, s_fb_o, s_first, s_last;
  logic         s_valid_o, s_ready_out, s_busy;
  logic [31:0]  s_instr;
  logic [1:0]   s_slot;
  logic [1:0]   s_cnt;

  // Single-slot instance: BLOCK_SIZE 1
  logic [7:0]   o_id, o_id_o;
  logic [31:0]  o_blk;
  logic         o_fb, o_valid, o_ready_in, o_flush, o_fb_o, o_first, o_last;
  logic         o_valid_o, o_ready_out, o_busy;
  logic [31:0]  o_instr;
  logic [0:0]   o_slot;
  logic [15:0]  o_cnt;

  ife_block_serializer #(.BLOCK_ID_WIDTH(8), .INSTR_WIDTH(32), .BLOCK_SIZE(4), .CNT_WIDTH(16)) u_main (
    .clk(clk), .rst(rst), .block_id_in(m_id), .block_in(m_blk), .is_fallback_in(m_fb),
    .valid_in(m_valid), .ready_in(m_ready_in), .flush(m_flush), .instr_out(m_instr),
    .slot_out(m_slot), .block_id_out(m_id_o), .is_fallback_out(m_fb_o), .first_out(m_first),
    .last_out(m_last), .valid_out(m_valid_o), .ready_out(m_ready_out), .busy(m_busy),
    .fallback_cnt(m_cnt));

  ife_block_serializer #(.BLOCK_ID_WIDTH(8), .INSTR_WIDTH(32), .BLOCK_SIZE(4), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .block_id_in(s_id), .block_in(s_blk), .is_fallback_in(s_fb),
    .valid_in(s_valid), .ready_in(s_ready_in), .flush(s_flush), .instr_out(s_instr),
    .slot_out(s_slot), .block_id_out(s_id_o), .is_fallback_out(s_fb_o), .first_out(s_first),
    .last_out(s_last), .valid_out(s_valid_o), .ready_out(s_ready_out), .busy(s_busy),
    .fallback_cnt(s_cnt));

  ife_block_serializer #(.BLOCK_ID_WIDTH(8), .INSTR_WIDTH(32), .BLOCK_SIZE(1), .CNT_WIDTH(16)) u_one (
    .clk(clk), .rst(rst), .block_id_in(o_id), .block_in(o_blk), .is_fallback_in(o_fb),
    .valid_in(o_valid), .ready_in(o_ready_in), .flush(o_flush), .instr_out(o_instr),
    .slot_out(o_slot), .block_id_out(o_id_o), .is_fallback_out(o_fb_o), .first_out(o_first),
    .last_out(o_last), .valid_out(o_valid_o), .ready_out(o_ready_out), .busy(o_busy),
    .fallback_cnt(o_cnt));

  typedef struct {
    logic        v;
    logic [7:0]  id;
    logic [31:0] base;
    logic        fb, ro, fl;
    logic        ev;
    logic [31:0] ebase;
    logic [1:0]  es;
    logic [7:0]  eid;
    logic        ef, el, eri, efb;
    logic [15:0] ecnt;
  } vec_t;

  localparam int NV = 27;
  vec_t tv [NV];

  function automatic logic [127:0] blk4(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [7:0] id, input logic [31:0] base,
                               input logic fb, input logic ro, input logic fl,
                               input logic ev, input logic [31:0] ebase, input logic [1:0] es,
                               input logic [7:0] eid, input logic ef, input logic el,
                               input logic eri, input logic efb, input logic [15:0] ecnt);
    vec_t r;
    r.v = v; r.id = id; r.base = base; r.fb = fb; r.ro = ro; r.fl = fl;
    r.ev = ev; r.ebase = ebase; r.es = es; r.eid = eid; r.ef = ef; r.el = el;
    r.eri = eri; r.efb = efb; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit found;

    // Cycle-by-cycle table for the main instance (inputs driven, then outputs checked)
    tv[0]  = mkv(1, 8'h12, KA, 0, 1, 0,  0, 0,  0, 8'h00, 0, 0, 1, 0, 0);
    tv[1]  = mkv(0, 8'h00, 0,  0, 1, 0,  1, KA, 0, 8'h12, 1, 0, 0, 0, 0);
    tv[2]  = mkv(0, 8'h00, 0,  0, 1, 0,  1, KA, 1, 8'h12, 0, 0, 0, 0, 0);
    tv[3]  = mkv(0, 8'h00, 0,  0, 1, 0,  1, KA, 2, 8'h12, 0, 0, 0, 0, 0);
    tv[4]  = mkv(0, 8'h00, 0,  0, 1, 0,  1, KA, 3, 8'h12, 0, 1, 1, 0, 0);
    tv[5]  = mkv(1, 8'h01, KB, 0, 1, 0,  0, 0,  0, 8'h00, 0, 0, 1, 0, 0);
    tv[6]  = mkv(1, 8'h02, KC, 1, 1, 0,  1, KB, 0, 8'h01, 1, 0, 0, 0, 0);
    tv[7]  = mkv(1, 8'h02, KC, 1, 1, 0,  1, KB, 1, 8'h01, 0, 0, 0, 0, 0);
    tv[8]  = mkv(1, 8'h02, KC, 1, 1, 0,  1, KB, 2, 8'h01, 0, 0, 0, 0, 0);
    tv[9]  = mkv(1, 8'h02, KC, 1, 1, 0,  1, KB, 3, 8'h01, 0, 1, 1, 0, 0);
    tv[10] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KC, 0, 8'h02, 1, 0, 0, 1, 1);
    tv[11] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KC, 1, 8'h02, 0, 0, 0, 1, 1);
    tv[12] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KC, 2, 8'h02, 0, 0, 0, 1, 1);
    tv[13] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KC, 3, 8'h02, 0, 1, 1, 1, 1);
    tv[14] = mkv(1, 8'h33, KD, 0, 1, 0,  0, 0,  0, 8'h00, 0, 0, 1, 0, 1);
    tv[15] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KD, 0, 8'h33, 1, 0, 0, 0, 1);
    tv[16] = mkv(0, 8'h00, 0,  0, 0, 0,  1, KD, 1, 8'h33, 0, 0, 0, 0, 1);
    tv[17] = mkv(1, 8'h55, KF, 1, 0, 0,  1, KD, 1, 8'h33, 0, 0, 0, 0, 1);
    tv[18] = mkv(0, 8'h00, 0,  0, 0, 0,  1, KD, 1, 8'h33, 0, 0, 0, 0, 1);
    tv[19] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KD, 1, 8'h33, 0, 0, 0, 0, 1);
    tv[20] = mkv(1, 8'h44, KE, 1, 1, 1,  1, KD, 2, 8'h33, 0, 0, 0, 0, 1);
    tv[21] = mkv(1, 8'h44, KE, 1, 1, 0,  0, 0,  0, 8'h00, 0, 0, 1, 0, 1);
    tv[22] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KE, 0, 8'h44, 1, 0, 0, 1, 2);
    tv[23] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KE, 1, 8'h44, 0, 0, 0, 1, 2);
    tv[24] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KE, 2, 8'h44, 0, 0, 0, 1, 2);
    tv[25] = mkv(0, 8'h00, 0,  0, 1, 0,  1, KE, 3, 8'h44, 0, 1, 1, 1, 2);
    tv[26] = mkv(0, 8'h00, 0,  0, 1, 0,  0, 0,  0, 8'h00, 0, 0, 1, 0, 2);

    rst = 1'b1;
    m_id = '0; m_blk = '0; m_fb = 0; m_valid = 0; m_flush = 0; m_ready_out = 0;
    s_id = '0; s_blk = '0; s_fb = 0; s_valid = 0; s_flush = 0; s_ready_out = 0;
    o_id = '0; o_blk = '0; o_fb = 0; o_valid = 0; o_flush = 0; o_ready_out = 0;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    chk("reset valid_out", m_valid_o, 0);
    chk("reset busy", m_busy, 0);
    chk("reset first_out", m_first, 0);
    chk("reset last_out", m_last, 0);
    chk("reset is_fallback_out", m_fb_o, 0);
    chk("reset instr_out", m_instr, 0);
    chk("reset slot_out", m_slot, 0);
    chk("reset block_id_out", m_id_o, 0);
    chk("reset fallback_cnt", m_cnt, 0);
    chk("reset ready_in", m_ready_in, 1);

    // Counter saturation with CNT_WIDTH = 2: five fallback blocks back to back
    s_valid = 1; s_fb = 1; s_ready_out = 1; s_id = 8'h5A; s_blk = blk4(KA);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
      found = 0;
      for (int t = 0; t < 12; t++) begin
        #1;
        if (s_ready_in) begin
          found = 1;
          break;
        end
        step();
      end
      if (!found) begin
        tests++;
        fails++;
        $display("FAIL sat accept %0d: ready_in never rose within 12 cycles", k);
      end
      step();
      chk($sformatf("sat fallback_cnt after block %0d", k), s_cnt, exp_cnt);
    end
    s_valid = 0;

    // Main table
    for (int i = 0; i < NV; i++) begin
      m_valid     = tv[i].v;
      m_id        = tv[i].id;
      m_blk       = tv[i].v ? blk4(tv[i].base) : '0;
      m_fb        = tv[i].fb;
      m_ready_out = tv[i].ro;
      m_flush     = tv[i].fl;
      #1;
      chk($sformatf("row%0d valid_out", i), m_valid_o, tv[i].ev);
      chk($sformatf("row%0d busy", i), m_busy, tv[i].ev);
      chk($sformatf("row%0d ready_in", i), m_ready_in, tv[i].eri);
      chk($sformatf("row%0d first_out", i), m_first, tv[i].ef);
      chk($sformatf("row%0d last_out", i), m_last, tv[i].el);
      chk($sformatf("row%0d fallback_cnt", i), m_cnt, tv[i].ecnt);
      if (tv[i].ev) begin
        chk($sformatf("row%0d instr_out", i), m_instr, tv[i].ebase + 32'(tv[i].es));
        chk($sformatf("row%0d slot_out", i), m_slot, tv[i].es);
        chk($sformatf("row%0d block_id_out", i), m_id_o, tv[i].eid);
        chk($sformatf("row%0d is_fallback_out", i), m_fb_o, tv[i].efb);
      end
      @(posedge clk);
      #2;
    end
    m_flush = 0;

    // Reset in the middle of a block
    m_valid = 1; m_id = 8'h66; m_blk = blk4(KA); m_fb = 1; m_ready_out = 1;
    step();
    m_valid = 0;
    step();
    #1;
    chk("midrst pre valid_out", m_valid_o, 1);
    chk("midrst pre slot_out", m_slot, 1);
    chk("midrst pre fallback_cnt", m_cnt, 3);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("midrst valid_out", m_valid_o, 0);
    chk("midrst busy", m_busy, 0);
    chk("midrst first_out", m_first, 0);
    chk("midrst last_out", m_last, 0);
    chk("midrst is_fallback_out", m_fb_o, 0);
    chk("midrst instr_out", m_instr, 0);
    chk("midrst slot_out", m_slot, 0);
    chk("midrst block_id_out", m_id_o, 0);
    chk("midrst fallback_cnt", m_cnt, 0);

    // BLOCK_SIZE = 1: two back-to-back single-beat blocks
    o_valid = 1; o_id = 8'h71; o_blk = KA; o_fb = 0; o_ready_out = 1;
    step();
    o_id = 8'h72; o_blk = KB; o_fb = 1;
    #1;
    chk("bs1 beat0 valid_out", o_valid_o, 1);
    chk("bs1 beat0 instr_out", o_instr, KA);
    chk("bs1 beat0 block_id_out", o_id_o, 8'h71);
    chk("bs1 beat0 first_out", o_first, 1);
    chk("bs1 beat0 last_out", o_last, 1);
    chk("bs1 beat0 ready_in", o_ready_in, 1);
    step();
    o_valid = 0;
    #1;
    chk("bs1 beat1 valid_out", o_valid_o, 1);
    chk("bs1 beat1 instr_out", o_instr, KB);
    chk("bs1 beat1 block_id_out", o_id_o, 8'h72);
    chk("bs1 beat1 first_out", o_first, 1);
    chk("bs1 beat1 last_out", o_last, 1);
    chk("bs1 beat1 is_fallback_out", o_fb_o, 1);
    chk("bs1 beat1 fallback_cnt", o_cnt, 1);
    step();
    #1;
    chk("bs1 idle valid_out", o_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
